// File: rtl/neuron_mac_sequencer.sv
// Sequences one shared pixel x weight multiplier over an image vector and accumulates a biased dot product.
// Optional NEURON_MAC_SATURATE_EN: saturating accumulation with a sticky sat_flag output.
module neuron_mac_sequencer #(
    parameter int unsigned PixelWidth  = 8,
    parameter int unsigned WeightWidth = 5,
    parameter int unsigned NumPixels   = 12288,
    parameter int unsigned AddrWidth   = 14,
    parameter int unsigned AccWidth    = 41
) (
    input  logic                                           clk,
    input  logic                                           resetN,
    input  logic                                           start,
    input  logic signed [AccWidth-1:0]                     bias,
    output logic        [AddrWidth-1:0]                    mem_addr,
    output logic                                           mem_rd,
    input  logic        [PixelWidth-1:0]                   pixel_data,
    input  logic signed [WeightWidth-1:0]                  weight_data,
    output logic        [PixelWidth:0]                     mul_p,
    output logic signed [WeightWidth-1:0]                  mul_w,
    input  logic signed [2*(PixelWidth+WeightWidth):0]     mul_result,
    output logic                                           busy,
    output logic                                           done,
    output logic signed [AccWidth-1:0]                     result,
`ifdef NEURON_MAC_SATURATE_EN
    output logic                                           sat_flag,
`endif
    output logic                                           is_cat
);

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumPixels - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                     state, state_d;
    logic [AddrWidth-1:0]       addr_d;
    logic                       rd_d, busy_d, done_d, is_cat_d, rd_valid, rd_valid_d;
    logic signed [AccWidth-1:0] acc, acc_d, result_d, prod_ext, sum;
`ifdef NEURON_MAC_SATURATE_EN
    logic                       sat_d, overflow;
    logic signed [AccWidth-1:0] sat_value;
`endif

    assign mul_p = {1'b0, pixel_data};
    assign mul_w = weight_data;

    assign prod_ext = AccWidth'(mul_result);
    assign sum      = acc + prod_ext;

`ifdef NEURON_MAC_SATURATE_EN
    // Overflow only possible when both addends share a sign that the sum does not.
    assign overflow  = (acc[AccWidth-1] == prod_ext[AccWidth-1]) && (sum[AccWidth-1] != acc[AccWidth-1]);
    assign sat_value = acc[AccWidth-1] ? {1'b1, {(AccWidth-1){1'b0}}} : {1'b0, {(AccWidth-1){1'b1}}};
`endif

    always_comb begin
        state_d    = state;
        addr_d     = mem_addr;
        rd_d       = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        acc_d      = acc;
        result_d   = result;
        is_cat_d   = is_cat;
        rd_valid_d = mem_rd;
`ifdef NEURON_MAC_SATURATE_EN
        sat_d      = sat_flag;
        if (rd_valid) begin
            acc_d = overflow ? sat_value : sum;
            sat_d = sat_flag | overflow;
        end
`else
        if (rd_valid) begin
            acc_d = sum;
        end
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    addr_d  = '0;
                    rd_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef NEURON_MAC_SATURATE_EN
                    sat_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                if (mem_addr == LastAddr) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = mem_addr + AddrWidth'(1);
                    rd_d   = 1'b1;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                done_d   = 1'b1;
                result_d = acc;
                is_cat_d = (acc > 0);
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc      <= '0;
            result   <= '0;
            is_cat   <= 1'b0;
`ifdef NEURON_MAC_SATURATE_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            mem_addr <= addr_d;
            mem_rd   <= rd_d;
            rd_valid <= rd_valid_d;
            busy     <= busy_d;
            done     <= done_d;
            acc      <= acc_d;
            result   <= result_d;
            is_cat   <= is_cat_d;
`ifdef NEURON_MAC_SATURATE_EN
            sat_flag <= sat_d;
`endif
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with a 4-pixel vector, synchronous RAM and multiplier models.
module tb_neuron_mac_sequencer;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    // Main instance: 4 pixels, 41-bit accumulator
    logic               start;
    logic signed [40:0] bias;
    logic [13:0]        mem_addr;
    logic               mem_rd;
    logic [7:0]         pixel_data;
    logic signed [4:0]  weight_data;
    logic [8:0]         mul_p;
    logic signed [4:0]  mul_w;
    logic signed [26:0] mul_result;
    logic               busy, done, is_cat;
    logic signed [40:0] result;
    logic [7:0]         pix [4];
    logic signed [4:0]  wt  [4];

    // Narrow instance: 28-bit accumulator for overflow behaviour
    logic               start28;
    logic signed [27:0] bias28;
    logic [13:0]        mem_addr28;
    logic               mem_rd28;
    logic [7:0]         pixel_data28;
    logic signed [4:0]  weight_data28;
    logic [8:0]         mul_p28;
    logic signed [4:0]  mul_w28;
    logic signed [26:0] mul_result28;
    logic               busy28, done28, is_cat28;
    logic signed [27:0] result28;
`ifdef NEURON_MAC_SATURATE_EN
    logic               sat_flag, sat_flag28;
`endif

    neuron_mac_sequencer #(.NumPixels(4)) dut (
        .clk(clk), .resetN(resetN), .start(start), .bias(bias),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .pixel_data(pixel_data), .weight_data(weight_data),
        .mul_p(mul_p), .mul_w(mul_w), .mul_result(mul_result),
        .busy(busy), .done(done), .result(result),
`ifdef NEURON_MAC_SATURATE_EN
        .sat_flag(sat_flag),
`endif
        .is_cat(is_cat)
    );

    neuron_mac_sequencer #(.NumPixels(4), .AccWidth(28)) dut28 (
        .clk(clk), .resetN(resetN), .start(start28), .bias(bias28),
        .mem_addr(mem_addr28), .mem_rd(mem_rd28), .pixel_data(pixel_data28), .weight_data(weight_data28),
        .mul_p(mul_p28), .mul_w(mul_w28), .mul_result(mul_result28),
        .busy(busy28), .done(done28), .result(result28),
`ifdef NEURON_MAC_SATURATE_EN
        .sat_flag(sat_flag28),
`endif
        .is_cat(is_cat28)
    );

    // Synchronous RAMs with one-cycle read latency and a combinational signed multiplier
    always @(posedge clk) begin
        if (mem_rd) begin
            pixel_data  <= pix[mem_addr[1:0]];
            weight_data <= wt[mem_addr[1:0]];
        end
        if (mem_rd28) begin
            pixel_data28  <= (mem_addr28 == 14'd0) ? 8'd255 : 8'd0;
            weight_data28 <= (mem_addr28 == 14'd0) ? 5'sd15 : 5'sd0;
        end
    end
    assign mul_result   = $signed(mul_p)   * mul_w;
    assign mul_result28 = $signed(mul_p28) * mul_w28;

    int n_checks = 0;
    int n_pass   = 0;

    int   done_cyc, rd_cnt, busy_cnt, done_cnt;
    logic addr_ok;

    task automatic load_vec(input logic [7:0] p0, p1, p2, p3, input int w0, w1, w2, w3);
        pix[0] = p0; pix[1] = p1; pix[2] = p2; pix[3] = p3;
        wt[0] = 5'(w0); wt[1] = 5'(w1); wt[2] = 5'(w2); wt[3] = 5'(w3);
    endtask

    // Start a run and observe each cycle after the start edge; optionally re-pulse start mid-run
    task automatic run(input logic signed [40:0] b, input bit extra_starts);
        done_cyc = -1; rd_cnt = 0; busy_cnt = 0; done_cnt = 0; addr_ok = 1'b1;
        @(negedge clk); bias = b; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (mem_rd) begin
                if (mem_addr != 14'(rd_cnt)) addr_ok = 1'b0;
                rd_cnt++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            start = extra_starts && (c == 2 || c == 4);
            if (done_cyc >= 0 && c > done_cyc + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        else n_pass++;
    endtask

    task automatic test_reset;
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_mem_rd", longint'(mem_rd), 0);
        check("reset_mem_addr", longint'(mem_addr), 0);
        check("reset_result", longint'(result), 0);
        check("reset_is_cat", longint'(is_cat), 0);
    endtask

    task automatic test_basic;
        load_vec(8'd10, 8'd20, 8'd30, 8'd255, 1, -2, 3, -16);
        run(41'sd5, 1'b0);
        check("basic_done_latency", done_cyc, 6);
        check("basic_done_pulses", done_cnt, 1);
        check("basic_reads", rd_cnt, 4);
        check("basic_addr_seq", longint'(addr_ok), 1);
        check("basic_result", longint'(result), -4015);
        check("basic_is_cat", longint'(is_cat), 0);
        repeat (3) @(negedge clk);
        check("basic_result_held", longint'(result), -4015);
    endtask

    task automatic test_positive;
        load_vec(8'd255, 8'd255, 8'd255, 8'd255, 15, 15, 15, 15);
        run(-41'sd100, 1'b0);
        check("pos_result", longint'(result), 15200);
        check("pos_is_cat", longint'(is_cat), 1);
        check("pos_busy_cycles", busy_cnt, 6);
    endtask

    task automatic test_overflow;
        int   waited;
        logic signed [27:0] exp_res;
        logic               exp_cat;
`ifdef NEURON_MAC_SATURATE_EN
        exp_res = 28'sd134217727; exp_cat = 1'b1;
`else
        exp_res = -28'sd134213931; exp_cat = 1'b0;
`endif
        @(negedge clk); bias28 = 28'sd134217700; start28 = 1'b1;
        @(negedge clk); start28 = 1'b0;
        waited = 0;
        while (!done28 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("acc28_done_seen", longint'(done28), 1);
        check("acc28_result", longint'(result28), longint'(exp_res));
        check("acc28_is_cat", longint'(is_cat28), longint'(exp_cat));
`ifdef NEURON_MAC_SATURATE_EN
        check("acc28_sat_flag", longint'(sat_flag28), 1);
        check("acc41_sat_flag_clear", longint'(sat_flag), 0);
`endif
    endtask

    task automatic test_restart_ignored;
        load_vec(8'd10, 8'd20, 8'd30, 8'd255, 1, -2, 3, -16);
        run(41'sd5, 1'b1);
        check("restart_done_pulses", done_cnt, 1);
        check("restart_done_latency", done_cyc, 6);
        check("restart_reads", rd_cnt, 4);
        check("restart_result", longint'(result), -4015);
    endtask

    task automatic test_mid_reset;
        load_vec(8'd255, 8'd255, 8'd255, 8'd255, 15, 15, 15, 15);
        @(negedge clk); bias = 41'sd7; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b0;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_mem_rd", longint'(mem_rd), 0);
        check("midrst_result", longint'(result), 0);
        check("midrst_is_cat", longint'(is_cat), 0);
        @(negedge clk); resetN = 1'b1;
        load_vec(8'd10, 8'd20, 8'd30, 8'd255, 1, -2, 3, -16);
        run(41'sd5, 1'b0);
        check("midrst_rerun_addr_seq", longint'(addr_ok), 1);
        check("midrst_rerun_reads", rd_cnt, 4);
        check("midrst_rerun_result", longint'(result), -4015);
    endtask

    task automatic test_zero_boundary;
        load_vec(8'd255, 8'd1, 8'd128, 8'd77, 0, 0, 0, 0);
        run(41'sd0, 1'b0);
        check("zero_done_latency", done_cyc, 6);
        check("zero_result", longint'(result), 0);
        check("zero_is_cat", longint'(is_cat), 0);
    endtask

    initial begin
        resetN = 1'b0; start = 1'b0; start28 = 1'b0; bias = '0; bias28 = '0;
        for (int i = 0; i < 4; i++) begin
            pix[i] = '0;
            wt[i]  = '0;
        end
        #1;
        test_reset;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        test_basic;
        test_positive;
        test_overflow;
        test_restart_ignored;
        test_mid_reset;
        test_zero_boundary;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
- Sequences one shared Neuron pixel×weight multiplier across a full image vector.
- Fetches pixel/weight pairs from external synchronous memories, drives the multiplier operands and accumulates the signed products onto a bias.
- Reports the final dot product and a cat / not-cat decision.
- Sits between the image/weight RAMs and the classifier output logic of CatRecognizer.

Parameters:
- PixelWidth, 8, unsigned pixel width.
- WeightWidth, 5, signed weight width.
- NumPixels, 12288, pairs per classification (64×64×3).
- AddrWidth, 14, memory address width; must satisfy 2^AddrWidth >= NumPixels.
- AccWidth, 41, signed accumulator width; must be >= 2*(PixelWidth+WeightWidth)+1.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a classification; sampled only in IDLE.
- bias  in  AccWidth  signed bias; loaded into the accumulator on the accepted start.
- mem_addr  out  AddrWidth  shared pixel/weight read address.
- mem_rd  out  1  read strobe; data returns exactly one cycle later.
- pixel_data  in  PixelWidth  pixel read data.
- weight_data  in  WeightWidth  signed weight read data.
- mul_p  out  PixelWidth+1  multiplier pixel operand: {1'b0, pixel_data}, combinational.
- mul_w  out  WeightWidth  multiplier weight operand: weight_data, combinational.
- mul_result  in  2*(PixelWidth+WeightWidth)+1  signed product from the combinational multiplier.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the result is valid.
- result  out  AccWidth  signed final sum; held until the next accepted start.
- is_cat  out  1  1 when result > 0; held with result.

Behaviour:
- Reset (async, resetN=0): state=IDLE; busy, done, mem_rd, is_cat = 0; mem_addr, accumulator, result = 0; rd_valid pipeline flag = 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start=1 at a rising edge: acc <= bias, mem_addr <= 0, mem_rd <= 1, busy <= 1, go to RUN.
  - result and is_cat are not cleared on start.
- RUN:
  - Each cycle, address k is presented with mem_rd=1; rd_valid <= mem_rd.
  - If mem_addr == NumPixels-1: mem_rd <= 0 and go to DRAIN. Otherwise mem_addr increments.
- Accumulate: on every edge where rd_valid=1, acc <= acc + sign_extend(mul_result). Product for address k is added at the end of the cycle after k was presented.
- DRAIN: performs the final accumulation (rd_valid=1), then goes to DONE.
- DONE (one cycle): done=1, result <= acc, is_cat <= (acc > 0), busy <= 0, then returns to IDLE. result and is_cat are registered, so they are valid from the done cycle onward.
- Latency: done is asserted NumPixels+2 cycles after the start edge. Exactly NumPixels reads are issued, with no gaps.
- start while busy=1 is ignored (no queuing, no restart).
- Reset mid-operation aborts immediately, with all outputs at their reset values; the partial sum is discarded.
- mem_addr holds its last value while idle. mem_rd is never asserted outside RUN.
- Arithmetic:
  - pixel_data is zero-padded to a signed operand.
  - The product is sign-extended to AccWidth.
  - Without the optional feature, the sum wraps two's-complement.

Optional Feature:
- Macro: NEURON_MAC_SATURATE_EN.
- Defined: each accumulation saturates to the AccWidth signed range, +(2^(AccWidth-1)-1) or -2^(AccWidth-1). Overflow is detected from the operand signs vs the sum sign. An internal sticky flag is exposed as an extra output, sat_flag (1 bit), cleared on start and on reset.
- Undefined: plain wrap-around addition; no sat_flag port.

Test Plan:
- NumPixels=4, bias=5, pixels [10,20,30,255], weights [1,-2,3,-16] -> done exactly 6 cycles after start; result=-4015, is_cat=0; mem_addr sequence 0,1,2,3 with mem_rd high for 4 cycles.
- NumPixels=4, bias=-100, all pixels 255, all weights 15 -> result=15200, is_cat=1; busy high for exactly 6 cycles.
- NumPixels=4, AccWidth=28, bias=134217700, pixels [255,0,0,0], weights [15,0,0,0]:
  - Macro off -> result=-134213931, is_cat=0.
  - Macro on -> result=134217727, is_cat=1, sat_flag=1.
- start pulsed again at cycles 2 and 4 of a run -> ignored; a single done; result identical to the single-start run.
- resetN driven low at cycle 3 of a run -> busy, done, mem_rd, result, is_cat all 0 immediately. A subsequent start runs correctly from address 0.
- bias=0, all weights 0 -> result=0, is_cat=0 (strict > 0 boundary).
